mode_counter: RTL and testbench

Parametrised successor to the free-running wrap counter used in the tiny-tapeout top levels. It adds programmable width, an inclusive upper bound, a clock prescaler, synchronous load, and four counting modes: up-wrap, down-wrap, up/down bounce and one-shot. It sits directly behind the top-level pin wrapper, driving `uo_out` from `counter_val_o` and taking its controls from `ui_in`/`uio_in`.

---
 rtl/mode_counter_pkg.sv | 18 +
 rtl/step_prescaler.sv | 36 +++
 rtl/mode_counter.sv | 148 ++++++++++++++
 tb/tb_mode_counter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
// Shared constants for mode_counter: counting-mode codes and the
// one-shot state encoding.
package mode_counter_pkg;

  // Counting modes selected by mode_i
  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  // One-shot sequencer states
  typedef enum logic [1:0] {
    OS_IDLE = 2'b00,
    OS_RUN  = 2'b01,
    OS_DONE = 2'b10
  } os_state_t;

endpackage

// File: rtl/step_prescaler.sv
// Clock prescaler: emits a one-cycle step strobe every div_i+1 enabled
// cycles. en_i low freezes the phase; clr_i restarts it from zero.
module step_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  step_o
);

  logic [PRESCALE_W-1:0] cnt_reg;

  // Strobe on the enabled cycle whose phase matches the divide field.
  // If div_i is lowered below the current phase, the count runs on and
  // wraps through zero before matching again.
  assign step_o = en_i && (cnt_reg == div_i);

  // Phase counter: clear on load, return to 0 on a step, else advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (step_o) begin
      cnt_reg <= '0;
    end else if (en_i) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Programmable-width counter with inclusive upper bound, prescaler,
// synchronous load and four modes: up-wrap, down-wrap, bounce, one-shot.
// Every output comes straight from a register.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [WIDTH-1:0]      top_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  input  logic                  start_i,
  output logic [WIDTH-1:0]      counter_val_o,
  output logic                  tc_o,
  output logic                  dir_o,
  output logic                  busy_o
);

  logic [WIDTH-1:0] val_reg;
  logic             tc_reg;
  logic             dir_reg;
  logic             busy_reg;
  os_state_t        state_reg;

  logic             step;
  logic [WIDTH-1:0] val_inc;
  logic [WIDTH-1:0] val_dec;
  logic             at_top;
  logic             inc_at_top;

  // A load restarts the prescaler phase so the next step is a full
  // period away.
  step_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (load_i),
    .div_i  (prescale_i),
    .step_o (step)
  );

  assign val_inc    = val_reg + WIDTH'(1);
  assign val_dec    = val_reg - WIDTH'(1);
  assign at_top     = (val_reg >= top_i);
  assign inc_at_top = (val_inc >= top_i);

  // Counter, direction, terminal-count pulse and one-shot sequencer.
  // Priority: load, then one-shot start, then a prescaled step, else hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      val_reg   <= '0;
      tc_reg    <= 1'b0;
      dir_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      state_reg <= OS_IDLE;
    end else begin
      tc_reg <= 1'b0;
      if (load_i) begin
        val_reg <= load_val_i;
      end else if ((mode_i == MODE_ONESHOT) && start_i && (state_reg != OS_RUN)) begin
        val_reg   <= '0;
        state_reg <= OS_RUN;
        busy_reg  <= 1'b1;
      end else if (step) begin
        // Any step outside one-shot mode abandons the one-shot sequence.
        if (mode_i != MODE_ONESHOT) begin
          state_reg <= OS_IDLE;
          busy_reg  <= 1'b0;
        end
        case (mode_i)
          MODE_UP: begin
            dir_reg <= 1'b0;
            if (at_top) begin
              val_reg <= '0;
              tc_reg  <= 1'b1;
            end else begin
              val_reg <= val_inc;
            end
          end
          MODE_DOWN: begin
            dir_reg <= 1'b1;
            if (val_reg == '0) begin
              val_reg <= top_i;
              tc_reg  <= 1'b1;
            end else begin
              val_reg <= val_dec;
            end
          end
          MODE_BOUNCE: begin
            // Direction is inherited from whatever mode ran before.
            if (top_i == '0) begin
              val_reg <= '0;
              tc_reg  <= 1'b1;
            end else if (!dir_reg) begin
              if (at_top) begin
                dir_reg <= 1'b1;
                val_reg <= val_dec;
                tc_reg  <= 1'b1;
              end else begin
                val_reg <= val_inc;
              end
            end else begin
              if (val_reg == '0) begin
                dir_reg <= 1'b0;
                val_reg <= val_inc;
                tc_reg  <= 1'b1;
              end else begin
                val_reg <= val_dec;
              end
            end
          end
          default: begin
            // One-shot: only RUN advances; IDLE and DONE hold the value.
            dir_reg <= 1'b0;
            if (state_reg == OS_RUN) begin
              if (at_top) begin
                state_reg <= OS_DONE;
                busy_reg  <= 1'b0;
                tc_reg    <= 1'b1;
              end else begin
                val_reg <= val_inc;
                if (inc_at_top) begin
                  state_reg <= OS_DONE;
                  busy_reg  <= 1'b0;
                  tc_reg    <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign counter_val_o = val_reg;
  assign tc_o          = tc_reg;
  assign dir_o         = dir_reg;
  assign busy_o        = busy_reg;

endmodule

// File: tb/tb_mode_counter.sv
// Scenario bench for mode_counter: each task queues per-cycle stimulus with
// the expected outputs, then replays the queue and compares cycle by cycle.
module tb_mode_counter;
  import mode_counter_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic [7:0] top_i = 8'd0;
  logic [3:0] prescale_i = 4'd0;
  logic       load_i = 1'b0;
  logic [7:0] load_val_i = 8'd0;
  logic       start_i = 1'b0;
  logic [7:0] counter_val_o;
  logic       tc_o;
  logic       dir_o;
  logic       busy_o;

  mode_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .top_i(top_i), .prescale_i(prescale_i), .load_i(load_i),
    .load_val_i(load_val_i), .start_i(start_i),
    .counter_val_o(counter_val_o), .tc_o(tc_o), .dir_o(dir_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Observed outputs packed as {value, tc, dir, busy}
  logic [10:0] obs;
  assign obs = {counter_val_o, tc_o, dir_o, busy_o};

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] top;
    logic [3:0] p;
    logic       load;
    logic [7:0] lval;
    logic       start;
  } stim_t;

  typedef struct {
    logic [10:0] val;
    logic [10:0] mask;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  stim_t s;
  exp_t  e;

  int checks = 0;
  int errors = 0;
  int idx;

  logic       cur_en;
  logic [1:0] cur_mode;
  logic [7:0] cur_top;
  logic [3:0] cur_p;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    en_i = cur_en; mode_i = cur_mode; top_i = cur_top; prescale_i = cur_p;
    load_i = 1'b0; load_val_i = 8'd0; start_i = 1'b0;
  endtask

  task automatic apply(input stim_t st);
    en_i = st.en; mode_i = st.mode; top_i = st.top; prescale_i = st.p;
    load_i = st.load; load_val_i = st.lval; start_i = st.start;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Queue one cycle of stimulus (current settings plus strobes) and the
  // outputs expected right after the following clock edge.
  task automatic push(input logic ld, input logic [7:0] lv, input logic st,
                      input logic [7:0] v, input logic t, input logic d,
                      input logic b, input logic dcare = 1'b1);
    stim_t sn;
    exp_t  en;
    sn.en = cur_en; sn.mode = cur_mode; sn.top = cur_top; sn.p = cur_p;
    sn.load = ld; sn.lval = lv; sn.start = st;
    en.val  = {v, t, d, b};
    en.mask = dcare ? 11'h7FF : 11'h7FD;
    stim_q.push_back(sn);
    exp_q.push_back(en);
  endtask

  task automatic test_reset();
    cur_en = 1'b1; cur_mode = MODE_UP; cur_top = 8'd5; cur_p = 4'd0;
    drive_idle();
    rst_i = 1'b1;
    tick();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 11'd0);
    end
    rst_i = 1'b0;
    for (int i = 1; i <= 5; i++) push(1'b0, 8'd0, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL up_wrap cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("up_wrap cycle %0d: obs %h", idx, obs);
      idx++;
    end
    // Reset mid-cycle, away from any clock edge
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, 11'd0);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_prescale();
    cur_en = 1'b1; cur_mode = MODE_UP; cur_top = 8'd255; cur_p = 4'd2;
    apply_reset();
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    cur_en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    cur_en = 1'b1;
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL prescale cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("prescale cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  task automatic test_down_load();
    cur_en = 1'b1; cur_mode = MODE_DOWN; cur_top = 8'd3; cur_p = 4'd0;
    apply_reset();
    push(1'b1, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
    push(1'b1, 8'd9, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0);
    for (int v = 8; v >= 0; v--) push(1'b0, 8'd0, 1'b0, 8'(v), 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL down_load cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("down_load cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  task automatic test_bounce();
    cur_en = 1'b1; cur_mode = MODE_BOUNCE; cur_top = 8'd2; cur_p = 4'd0;
    apply_reset();
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
    cur_top = 8'd0;
    push(1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("bounce cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  task automatic test_mode_change();
    cur_en = 1'b1; cur_mode = MODE_DOWN; cur_top = 8'd3; cur_p = 4'd0;
    apply_reset();
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0);
    cur_mode = MODE_BOUNCE;
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    cur_mode = MODE_DOWN;
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cur_mode = MODE_UP;
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL mode_change cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("mode_change cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  task automatic test_oneshot();
    cur_en = 1'b1; cur_mode = MODE_ONESHOT; cur_top = 8'd3; cur_p = 4'd0;
    apply_reset();
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL oneshot cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("oneshot cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  task automatic test_simultaneous();
    cur_en = 1'b1; cur_mode = MODE_UP; cur_top = 8'd3; cur_p = 4'd1;
    apply_reset();
    push(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    push(1'b1, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); tick(); e = exp_q.pop_front(); checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %h want %h", idx, obs, e.val);
      end
      $display("simultaneous cycle %0d: obs %h", idx, obs);
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_down_load();
    test_bounce();
    test_mode_change();
    test_oneshot();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
